// File: rtl/z_core_lsu_if.sv
// Request/response and AXI-Lite bundle for z_core_lsu.
// master = LSU side (drives AXI requests and core responses), slave = core + memory side.
interface z_core_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] m_axil_awaddr;
  logic                  m_axil_awvalid;
  logic                  m_axil_awready;
  logic [31:0]           m_axil_wdata;
  logic [3:0]            m_axil_wstrb;
  logic                  m_axil_wvalid;
  logic                  m_axil_wready;
  logic [1:0]            m_axil_bresp;
  logic                  m_axil_bvalid;
  logic                  m_axil_bready;
  logic [ADDR_WIDTH-1:0] m_axil_araddr;
  logic                  m_axil_arvalid;
  logic                  m_axil_arready;
  logic [31:0]           m_axil_rdata;
  logic [1:0]            m_axil_rresp;
  logic                  m_axil_rvalid;
  logic                  m_axil_rready;

  modport master (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_axil_awaddr, m_axil_awvalid, m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    output m_axil_bready, m_axil_araddr, m_axil_arvalid, m_axil_rready,
    input  m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
    input  m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid
  );

  modport slave (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_axil_awaddr, m_axil_awvalid, m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    input  m_axil_bready, m_axil_araddr, m_axil_arvalid, m_axil_rready,
    output m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
    output m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid
  );
endinterface

// File: rtl/z_core_lsu.sv
// Single-outstanding RV32 load/store unit bridging core requests onto AXI-Lite.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of ignoring low address bits.
module z_core_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rstn,
  z_core_lsu_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            lane_q, lane_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic                  illegal_c, misalign_c, timeout_c;
  logic [3:0]            st_strb_c;
  logic [31:0]           st_data_c, load_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;

  // Request decode: legality and store lane formatting.
  always_comb begin
    illegal_c  = (bus.req_size == 3'b011) || (bus.req_size[2:1] == 2'b11) ||
                 (bus.req_we && bus.req_size[2]);
    misalign_c = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_c = ((bus.req_size[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_size[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`endif
    case (bus.req_size[1:0])
      2'b00: begin
        st_strb_c = 4'b0001 << bus.req_addr[1:0];
        st_data_c = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        st_strb_c = 4'b0011 << {bus.req_addr[1], 1'b0};
        st_data_c = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        st_strb_c = 4'b1111;
        st_data_c = bus.req_wdata;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    case (lane_q)
      2'd0:    byte_c = bus.m_axil_rdata[7:0];
      2'd1:    byte_c = bus.m_axil_rdata[15:8];
      2'd2:    byte_c = bus.m_axil_rdata[23:16];
      default: byte_c = bus.m_axil_rdata[31:24];
    endcase
    half_c = lane_q[1] ? bus.m_axil_rdata[31:16] : bus.m_axil_rdata[15:0];
    case (size_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_c = {24'h0, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'h0, half_c};
      default: load_c = bus.m_axil_rdata;
    endcase
  end

  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next state; handshake outputs are registered from the next state.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    lane_d      = lane_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    awvalid_d   = 1'b0;
    wvalid_d    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          size_d  = bus.req_size;
          lane_d  = bus.req_addr[1:0];
          addr_d  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = st_data_c;
          wstrb_d = st_strb_c;
          if (illegal_c || misalign_c) begin
            state_d   = S_DONE;
            rsp_err_d = 1'b1;
          end else if (bus.req_we) begin
            state_d   = S_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = S_RADDR;
          end
        end
      end
      S_WADDR: begin
        awvalid_d = awvalid_q && !bus.m_axil_awready;
        wvalid_d  = wvalid_q && !bus.m_axil_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d = S_WRESP;
          cnt_d   = '0;
        end
      end
      S_WRESP: begin
        if (bus.m_axil_bvalid) begin
          state_d   = S_DONE;
          rsp_err_d = (bus.m_axil_bresp != 2'b00);
        end else if (timeout_c) begin
          state_d   = S_DONE;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      S_RADDR: begin
        if (bus.m_axil_arready) begin
          state_d = S_RDATA;
          cnt_d   = '0;
        end
      end
      S_RDATA: begin
        if (bus.m_axil_rvalid) begin
          state_d = S_DONE;
          if (bus.m_axil_rresp != 2'b00) rsp_err_d = 1'b1;
          else                           rsp_rdata_d = load_c;
        end else if (timeout_c) begin
          state_d   = S_DONE;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    bready_d    = (state_d == S_WRESP);
    arvalid_d   = (state_d == S_RADDR);
    rready_d    = (state_d == S_RDATA);
    rsp_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      size_q      <= 3'b000;
      lane_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.m_axil_awaddr  = addr_q;
  assign bus.m_axil_awvalid = awvalid_q;
  assign bus.m_axil_wdata   = wdata_q;
  assign bus.m_axil_wstrb   = wstrb_q;
  assign bus.m_axil_wvalid  = wvalid_q;
  assign bus.m_axil_bready  = bready_q;
  assign bus.m_axil_araddr  = addr_q;
  assign bus.m_axil_arvalid = arvalid_q;
  assign bus.m_axil_rready  = rready_q;

endmodule

// File: tb/tb_z_core_lsu.sv
// Directed bench for z_core_lsu with a negedge-driven AXI-Lite memory slave (TIMEOUT=4).
module tb_z_core_lsu;

  logic clk;
  logic rstn;

  z_core_lsu_if #(.ADDR_WIDTH(32)) bus ();

  z_core_lsu #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total;
  int bad;

  // slave knobs and state
  int          aw_lag, w_lag, aw_cnt, w_cnt;
  bit          b_hold, r_hold, aw_got, w_got, ar_got;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] aw_addr, w_data, ar_addr;
  logic [3:0]  w_strb;
  logic [31:0] mem [0:255];

  // observed transaction results
  logic [31:0] r_rdata, mon_awaddr, mon_wdata, mon_araddr;
  logic [3:0]  mon_wstrb;
  bit          r_err, saw_aw, saw_w, saw_ar;
  int          r_lat;

  // Memory slave: decisions taken on the falling edge, seen by the DUT on the next rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      bus.m_axil_awready = 1'b0; bus.m_axil_wready = 1'b0; bus.m_axil_arready = 1'b0;
      bus.m_axil_bvalid  = 1'b0; bus.m_axil_rvalid = 1'b0;
      bus.m_axil_bresp   = 2'b00; bus.m_axil_rresp = 2'b00; bus.m_axil_rdata = 32'h0;
      aw_cnt = 0; w_cnt = 0; aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
    end else begin
      bus.m_axil_awready = 1'b0; bus.m_axil_wready = 1'b0; bus.m_axil_arready = 1'b0;
      bus.m_axil_bvalid  = 1'b0; bus.m_axil_rvalid = 1'b0;
      if (bus.m_axil_awvalid) begin
        aw_cnt++;
        if (aw_cnt > aw_lag) begin
          bus.m_axil_awready = 1'b1; aw_got = 1'b1; aw_addr = bus.m_axil_awaddr; aw_cnt = 0;
        end
      end
      if (bus.m_axil_wvalid) begin
        w_cnt++;
        if (w_cnt > w_lag) begin
          bus.m_axil_wready = 1'b1; w_got = 1'b1; w_data = bus.m_axil_wdata;
          w_strb = bus.m_axil_wstrb; w_cnt = 0;
        end
      end
      if (bus.m_axil_bready && aw_got && w_got && !b_hold) begin
        for (int k = 0; k < 4; k++)
          if (w_strb[k]) mem[aw_addr[9:2]][8*k +: 8] = w_data[8*k +: 8];
        bus.m_axil_bvalid = 1'b1; bus.m_axil_bresp = b_resp; aw_got = 1'b0; w_got = 1'b0;
      end
      if (bus.m_axil_arvalid) begin
        bus.m_axil_arready = 1'b1; ar_got = 1'b1; ar_addr = bus.m_axil_araddr;
      end
      if (bus.m_axil_rready && ar_got && !r_hold) begin
        bus.m_axil_rvalid = 1'b1; bus.m_axil_rdata = mem[ar_addr[9:2]];
        bus.m_axil_rresp = r_resp; ar_got = 1'b0;
      end
    end
  end

  // Issue one request and watch the bus until the completion pulse (bounded).
  task automatic do_req(input bit we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bit got;
    got = 1'b0;
    r_rdata = 32'h0; r_err = 1'b0; r_lat = 0;
    saw_aw = 1'b0; saw_w = 1'b0; saw_ar = 1'b0;
    mon_awaddr = 32'h0; mon_wdata = 32'h0; mon_wstrb = 4'h0; mon_araddr = 32'h0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (bus.m_axil_awvalid) begin saw_aw = 1'b1; mon_awaddr = bus.m_axil_awaddr; end
      if (bus.m_axil_wvalid) begin
        saw_w = 1'b1; mon_wdata = bus.m_axil_wdata; mon_wstrb = bus.m_axil_wstrb;
      end
      if (bus.m_axil_arvalid) begin saw_ar = 1'b1; mon_araddr = bus.m_axil_araddr; end
      if (bus.rsp_valid) begin
        got = 1'b1; r_lat = i; r_rdata = bus.rsp_rdata; r_err = bus.rsp_err;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rsp_timeout: no rsp_valid within 40 cycles for addr %h size %b we %0d", addr, size, we);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_bready, bus.m_axil_arvalid,
         bus.m_axil_rready, bus.rsp_valid, bus.rsp_err} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs: some valid/ready/rsp output nonzero in reset");
    end
    total++;
    if (bus.rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 00000000", bus.rsp_rdata);
    end
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_word;
    do_req(1'b1, 3'b010, 32'h100, 32'h0000_0008);
    total++; if (mon_awaddr !== 32'h100) begin bad++; $display("FAIL sw_awaddr: got %h want 00000100", mon_awaddr); end
    total++; if (mon_wstrb !== 4'b1111) begin bad++; $display("FAIL sw_wstrb: got %b want 1111", mon_wstrb); end
    total++; if (mon_wdata !== 32'h8) begin bad++; $display("FAIL sw_wdata: got %h want 00000008", mon_wdata); end
    total++; if (r_err !== 1'b0) begin bad++; $display("FAIL sw_err: got %b want 0", r_err); end
    total++; if (r_lat != 3) begin bad++; $display("FAIL sw_latency: got %0d want 3", r_lat); end
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_pulse_width: rsp_valid %b want 0", bus.rsp_valid); end
    do_req(1'b0, 3'b010, 32'h100, 32'h0);
    total++; if (mon_araddr !== 32'h100) begin bad++; $display("FAIL lw_araddr: got %h want 00000100", mon_araddr); end
    total++; if (r_rdata !== 32'h8) begin bad++; $display("FAIL lw_rdata: got %h want 00000008", r_rdata); end
    total++; if (r_lat != 3) begin bad++; $display("FAIL lw_latency: got %0d want 3", r_lat); end
  endtask

  task automatic test_byte;
    do_req(1'b1, 3'b000, 32'h103, 32'h0000_00A5);
    total++; if (mon_wstrb !== 4'b1000) begin bad++; $display("FAIL sb_wstrb: got %b want 1000", mon_wstrb); end
    total++; if (mon_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", mon_wdata); end
    total++; if (mon_awaddr !== 32'h100) begin bad++; $display("FAIL sb_awaddr: got %h want 00000100", mon_awaddr); end
    do_req(1'b0, 3'b000, 32'h103, 32'h0);
    total++; if (r_rdata !== 32'hFFFFFFA5) begin bad++; $display("FAIL lb_rdata: got %h want ffffffa5", r_rdata); end
    do_req(1'b0, 3'b100, 32'h103, 32'h0);
    total++; if (r_rdata !== 32'h000000A5) begin bad++; $display("FAIL lbu_rdata: got %h want 000000a5", r_rdata); end
    do_req(1'b0, 3'b000, 32'h100, 32'h0);
    total++; if (r_rdata !== 32'h00000008) begin bad++; $display("FAIL lb0_rdata: got %h want 00000008", r_rdata); end
  endtask

  task automatic test_half;
    do_req(1'b1, 3'b010, 32'h100, 32'h8001_1234);
    do_req(1'b0, 3'b001, 32'h102, 32'h0);
    total++; if (r_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL lh_hi_rdata: got %h want ffff8001", r_rdata); end
    do_req(1'b0, 3'b101, 32'h102, 32'h0);
    total++; if (r_rdata !== 32'h00008001) begin bad++; $display("FAIL lhu_hi_rdata: got %h want 00008001", r_rdata); end
    do_req(1'b0, 3'b001, 32'h100, 32'h0);
    total++; if (r_rdata !== 32'h00001234) begin bad++; $display("FAIL lh_lo_rdata: got %h want 00001234", r_rdata); end
    do_req(1'b1, 3'b001, 32'h102, 32'h0000_BEEF);
    total++; if (mon_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_wstrb: got %b want 1100", mon_wstrb); end
    total++; if (mon_wdata !== 32'hBEEFBEEF) begin bad++; $display("FAIL sh_wdata: got %h want beefbeef", mon_wdata); end
    do_req(1'b1, 3'b000, 32'h101, 32'h0000_0077);
    total++; if (mon_wstrb !== 4'b0010) begin bad++; $display("FAIL sb1_wstrb: got %b want 0010", mon_wstrb); end
    do_req(1'b0, 3'b010, 32'h100, 32'h0);
    total++; if (r_rdata !== 32'hBEEF7734) begin bad++; $display("FAIL lw_merge_rdata: got %h want beef7734", r_rdata); end
  endtask

  task automatic test_order;
    aw_lag = 2; w_lag = 0;
    do_req(1'b1, 3'b010, 32'h104, 32'hCAFE_F00D);
    total++; if (r_lat != 5 || r_err !== 1'b0) begin bad++; $display("FAIL w_first: lat %0d err %b want 5 0", r_lat, r_err); end
    aw_lag = 0; w_lag = 2;
    do_req(1'b1, 3'b010, 32'h108, 32'h1234_5678);
    total++; if (r_lat != 5 || r_err !== 1'b0) begin bad++; $display("FAIL aw_first: lat %0d err %b want 5 0", r_lat, r_err); end
    w_lag = 0;
    do_req(1'b0, 3'b010, 32'h104, 32'h0);
    total++; if (r_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL w_first_data: got %h want cafef00d", r_rdata); end
    do_req(1'b0, 3'b010, 32'h108, 32'h0);
    total++; if (r_rdata !== 32'h12345678) begin bad++; $display("FAIL aw_first_data: got %h want 12345678", r_rdata); end
  endtask

  task automatic test_errors;
    r_resp = 2'b10;
    do_req(1'b0, 3'b010, 32'h100, 32'h0);
    r_resp = 2'b00;
    total++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin bad++; $display("FAIL rresp_err: err %b rdata %h want 1 00000000", r_err, r_rdata); end
    b_resp = 2'b10;
    do_req(1'b1, 3'b010, 32'h10C, 32'h1);
    b_resp = 2'b00;
    total++; if (r_err !== 1'b1) begin bad++; $display("FAIL bresp_err: got %b want 1", r_err); end
    b_hold = 1'b1;
    do_req(1'b1, 3'b010, 32'h110, 32'h2);
    total++; if (r_err !== 1'b1 || r_lat != 6) begin bad++; $display("FAIL b_timeout: err %b lat %0d want 1 6", r_err, r_lat); end
    @(negedge clk);
    total++; if (bus.m_axil_bready !== 1'b0) begin bad++; $display("FAIL b_timeout_bready: got %b want 0", bus.m_axil_bready); end
    b_hold = 1'b0;
    r_hold = 1'b1;
    do_req(1'b0, 3'b010, 32'h100, 32'h0);
    total++; if (r_err !== 1'b1 || r_lat != 6 || r_rdata !== 32'h0) begin bad++; $display("FAIL r_timeout: err %b lat %0d rdata %h want 1 6 00000000", r_err, r_lat, r_rdata); end
    r_hold = 1'b0;
    do_req(1'b0, 3'b011, 32'h100, 32'h0);
    total++; if (r_err !== 1'b1 || r_lat != 1 || saw_ar) begin bad++; $display("FAIL size011: err %b lat %0d ar %b want 1 1 0", r_err, r_lat, saw_ar); end
    do_req(1'b1, 3'b100, 32'h100, 32'h0);
    total++; if (r_err !== 1'b1 || saw_aw || saw_w) begin bad++; $display("FAIL store_bu: err %b aw %b w %b want 1 0 0", r_err, saw_aw, saw_w); end
    do_req(1'b0, 3'b111, 32'h100, 32'h0);
    total++; if (r_err !== 1'b1 || saw_ar) begin bad++; $display("FAIL size111: err %b ar %b want 1 0", r_err, saw_ar); end
  endtask

  task automatic test_misalign;
    do_req(1'b1, 3'b010, 32'h100, 32'h8001_1234);
    do_req(1'b0, 3'b010, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    total++; if (r_err !== 1'b1 || r_lat != 1 || saw_ar) begin bad++; $display("FAIL lw_mis_trap: err %b lat %0d ar %b want 1 1 0", r_err, r_lat, saw_ar); end
    do_req(1'b0, 3'b001, 32'h103, 32'h0);
    total++; if (r_err !== 1'b1 || saw_ar) begin bad++; $display("FAIL lh_mis_trap: err %b ar %b want 1 0", r_err, saw_ar); end
    do_req(1'b1, 3'b010, 32'h102, 32'hDEAD_BEEF);
    total++; if (r_err !== 1'b1 || saw_aw || saw_w) begin bad++; $display("FAIL sw_mis_trap: err %b aw %b w %b want 1 0 0", r_err, saw_aw, saw_w); end
`else
    total++; if (r_err !== 1'b0 || mon_araddr !== 32'h100) begin bad++; $display("FAIL lw_mis_addr: err %b araddr %h want 0 00000100", r_err, mon_araddr); end
    total++; if (r_rdata !== 32'h80011234) begin bad++; $display("FAIL lw_mis_data: got %h want 80011234", r_rdata); end
    do_req(1'b0, 3'b001, 32'h103, 32'h0);
    total++; if (r_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL lh_mis_data: got %h want ffff8001", r_rdata); end
    do_req(1'b1, 3'b010, 32'h102, 32'hDEAD_BEEF);
    total++; if (mon_wstrb !== 4'b1111 || mon_awaddr !== 32'h100) begin bad++; $display("FAIL sw_mis: wstrb %b awaddr %h want 1111 00000100", mon_wstrb, mon_awaddr); end
`endif
  endtask

  task automatic test_reset_mid;
    bit seen;
    int late;
    seen = 1'b0;
    late = 0;
    r_hold = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 3'b010; bus.req_addr = 32'h100;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.m_axil_rready) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL mid_rdata_entry: rready never rose"); end
    #2 rstn = 1'b0;
    #1;
    total++; if (bus.m_axil_rready !== 1'b0 || bus.m_axil_arvalid !== 1'b0) begin bad++; $display("FAIL mid_reset_ready: rready %b arvalid %b want 0 0", bus.m_axil_rready, bus.m_axil_arvalid); end
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL mid_reset_rsp: valid %b err %b want 0 0", bus.rsp_valid, bus.rsp_err); end
    r_hold = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) late++;
    end
    total++; if (late != 0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_idle: late pulses %0d ready %b want 0 1", late, bus.req_ready); end
    do_req(1'b1, 3'b010, 32'h100, 32'h1357_9BDF);
    do_req(1'b0, 3'b010, 32'h100, 32'h0);
    total++; if (r_rdata !== 32'h13579BDF || r_lat != 3) begin bad++; $display("FAIL post_reset_lw: rdata %h lat %0d want 13579bdf 3", r_rdata, r_lat); end
  endtask

  initial begin
    total = 0; bad = 0;
    clk = 1'b0; rstn = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    aw_lag = 0; w_lag = 0; b_hold = 1'b0; r_hold = 1'b0; b_resp = 2'b00; r_resp = 2'b00;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_order;
    test_errors;
    test_misalign;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
